// File: rtl/covert_pkg.sv
// Shared types and constants for the covert-channel trial controller and its
// LFSR pattern generator.
package covert_pkg;

    localparam int STR_LEN_DEF     = 32;
    localparam int LOG_STR_LEN_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_SEND       = 3'd2,
        ST_WAIT_RX    = 3'd3,
        ST_WAIT_MATCH = 3'd4,
        ST_ACCUM      = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    // Maximal-length Fibonacci tap masks (bit i set = stage i+1 tapped).
    function automatic logic [63:0] lfsr_taps(input int len);
        logic [63:0] t;
        case (len)
            8:       t = 64'h0000_0000_0000_00B8;
            16:      t = 64'h0000_0000_0000_D008;
            32:      t = 64'h0000_0000_8020_0003;
            64:      t = 64'hD800_0000_0000_0000;
            default: t = (64'd3 << (len - 2));
        endcase
        return t;
    endfunction

endpackage

// File: rtl/covert_lfsr_step.sv
// One combinational step of a Fibonacci LFSR; shifts left, feedback into bit 0.
// An all-zero input is mapped to 1 so the sequence can never lock up.
module lfsr_step
    import covert_pkg::*;
#(
    parameter int STR_LEN = STR_LEN_DEF
) (
    input  logic [STR_LEN-1:0] cur,
    output logic [STR_LEN-1:0] nxt
);

    localparam logic [63:0]        TAPS_ALL = lfsr_taps(STR_LEN);
    localparam logic [STR_LEN-1:0] TAPS     = TAPS_ALL[STR_LEN-1:0];

    logic fb;

    always_comb begin
        fb  = ^(cur & TAPS);
        nxt = {cur[STR_LEN-2:0], fb};
        if (cur == '0) begin
            nxt = STR_LEN'(1);
        end
    end

endmodule

// File: rtl/covert_trial_ctrl.sv
// Trial sequencer: offers a string per trial, waits for receiver and checker,
// and accumulates run statistics. Restarts peers with trial_clear between trials.
module covert_trial_ctrl
    import covert_pkg::*;
#(
    parameter int STR_LEN     = STR_LEN_DEF,
    parameter int LOG_STR_LEN = LOG_STR_LEN_DEF,
    parameter int NUM_TRIALS  = 16,
    parameter int TIMEOUT     = 4096,
    localparam int CW  = $clog2(NUM_TRIALS + 1),
    localparam int EW  = LOG_STR_LEN + 1,
    localparam int TEW = LOG_STR_LEN + 1 + CW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [STR_LEN-1:0]     seed,
    input  logic [LOG_STR_LEN-1:0] eos_cfg,
    // tx handshake: tx_valid holds with stable tx_string/tx_eos until the
    // cycle where tx_valid && tx_ready, which is the single transfer.
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [STR_LEN-1:0]     tx_string,
    output logic [LOG_STR_LEN-1:0] tx_eos,
    input  logic                   rx_ready,
    input  logic                   match_done,
    input  logic                   match_equal,
    input  logic [EW-1:0]          match_errors,
    output logic                   trial_clear,
    output logic                   busy,
    output logic                   done,
    output logic [CW-1:0]          trial_count,
    output logic [TEW-1:0]         total_errors,
    output logic [CW-1:0]          equal_count,
    output logic [CW-1:0]          timeout_count,
    output state_t                 state_dbg
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t state, state_nxt;

    logic [STR_LEN-1:0]     str_q;
    logic [STR_LEN-1:0]     str_adv;
    logic [LOG_STR_LEN-1:0] eos_q;
    logic [TW-1:0]          to_cnt;
    logic [EW-1:0]          cap_err;
    logic                   cap_eq;
    logic                   waiting;
    logic                   timeout_hit;

    lfsr_step #(.STR_LEN(STR_LEN)) u_lfsr (
        .cur (str_q),
        .nxt (str_adv)
    );

    // A match_done in the expiry cycle counts as a completed trial.
    assign waiting     = (state == ST_WAIT_RX) || (state == ST_WAIT_MATCH);
    assign timeout_hit = waiting && (to_cnt == TW'(TIMEOUT - 1))
                         && !((state == ST_WAIT_MATCH) && match_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_LOAD;
            ST_LOAD:          state_nxt = ST_SEND;
            ST_SEND:          if (tx_ready) state_nxt = ST_WAIT_RX;
            ST_WAIT_RX: begin
                if (timeout_hit)   state_nxt = ST_ACCUM;
                else if (rx_ready) state_nxt = ST_WAIT_MATCH;
            end
            ST_WAIT_MATCH:    if (match_done || timeout_hit) state_nxt = ST_ACCUM;
            ST_ACCUM: begin
                if (trial_count == CW'(NUM_TRIALS - 1)) state_nxt = ST_DONE;
                else                                    state_nxt = ST_LOAD;
            end
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_valid    = (state == ST_SEND);
        trial_clear = (state == ST_ACCUM);
        busy        = (state != ST_IDLE) && (state != ST_DONE);
        done        = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            str_q         <= '0;
            eos_q         <= '0;
            to_cnt        <= '0;
            cap_err       <= '0;
            cap_eq        <= 1'b0;
            trial_count   <= '0;
            total_errors  <= '0;
            equal_count   <= '0;
            timeout_count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        str_q         <= (seed == '0) ? STR_LEN'(1) : seed;
                        eos_q         <= eos_cfg;
                        trial_count   <= '0;
                        total_errors  <= '0;
                        equal_count   <= '0;
                        timeout_count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (trial_count != '0) str_q <= str_adv;
                end
                ST_SEND: begin
                    if (tx_ready) to_cnt <= '0;
                end
                ST_WAIT_RX, ST_WAIT_MATCH: begin
                    to_cnt <= to_cnt + TW'(1);
                    if ((state == ST_WAIT_MATCH) && match_done) begin
                        cap_err <= match_errors;
                        cap_eq  <= match_equal;
                    end else if (timeout_hit) begin
                        // Every compared bit is charged as an error.
                        cap_err       <= EW'(STR_LEN) - EW'(eos_q);
                        cap_eq        <= 1'b0;
                        timeout_count <= timeout_count + CW'(1);
                    end
                end
                ST_ACCUM: begin
                    total_errors <= total_errors + TEW'(cap_err);
                    equal_count  <= equal_count + CW'(cap_eq);
                    trial_count  <= trial_count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign tx_string = str_q;
    assign tx_eos    = eos_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_covert_trial_ctrl.sv
// Directed bench for covert_trial_ctrl: four-trial runs with scripted peer
// responses, hand-computed LFSR strings and run statistics.
module tb_covert_trial_ctrl;
    import covert_pkg::*;

    localparam int STR_LEN     = 32;
    localparam int LOG_STR_LEN = 5;
    localparam int NUM_TRIALS  = 4;
    localparam int TIMEOUT     = 64;
    localparam int CW          = $clog2(NUM_TRIALS + 1);
    localparam int EW          = LOG_STR_LEN + 1;
    localparam int TEW         = LOG_STR_LEN + 1 + CW;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [STR_LEN-1:0]     seed = '0;
    logic [LOG_STR_LEN-1:0] eos_cfg = '0;
    logic                   tx_valid;
    logic                   tx_ready = 1'b0;
    logic [STR_LEN-1:0]     tx_string;
    logic [LOG_STR_LEN-1:0] tx_eos;
    logic                   rx_ready = 1'b0;
    logic                   match_done = 1'b0;
    logic                   match_equal = 1'b0;
    logic [EW-1:0]          match_errors = '0;
    logic                   trial_clear;
    logic                   busy;
    logic                   done;
    logic [CW-1:0]          trial_count;
    logic [TEW-1:0]         total_errors;
    logic [CW-1:0]          equal_count;
    logic [CW-1:0]          timeout_count;
    state_t                 state_dbg;

    int checks = 0;
    int errors = 0;
    int clr_pulses = 0;

    covert_trial_ctrl #(
        .STR_LEN(STR_LEN), .LOG_STR_LEN(LOG_STR_LEN),
        .NUM_TRIALS(NUM_TRIALS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .eos_cfg(eos_cfg),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_string(tx_string), .tx_eos(tx_eos),
        .rx_ready(rx_ready), .match_done(match_done), .match_equal(match_equal),
        .match_errors(match_errors), .trial_clear(trial_clear), .busy(busy), .done(done),
        .trial_count(trial_count), .total_errors(total_errors), .equal_count(equal_count),
        .timeout_count(timeout_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (trial_clear) clr_pulses++;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [STR_LEN-1:0] s, input logic [LOG_STR_LEN-1:0] e);
        start = 1'b1; seed = s; eos_cfg = e;
        @(negedge clk);
        start = 1'b0; seed = 32'hFFFF_FFFF; eos_cfg = '1;
        clr_pulses = 0;
        check("start_load", state_dbg, ST_LOAD);
        check("start_busy", busy, 1);
    endtask

    // Cycle c = 0 is the first cycle after the tx handshake edge; rx_at/md_at
    // pick the cycle carrying rx_ready/match_done (-1 = never).
    task automatic drive_trial(input int hold, input int rx_at, input int md_at,
                               input logic [EW-1:0] errs, input logic eq,
                               input logic [STR_LEN-1:0] exp_str);
        int waited = 0;
        int last;
        logic [STR_LEN-1:0] s0;
        logic stable = 1'b1;
        while (!tx_valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("tx_valid_rise", tx_valid, 1);
        check("tx_string", tx_string, exp_str);
        s0 = tx_string;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!tx_valid || tx_string !== s0) stable = 1'b0;
        end
        if (hold > 0) check("tx_hold_stable", stable, 1);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("tx_valid_fall", tx_valid, 0);
        last = (md_at >= 0) ? md_at : TIMEOUT - 1;
        for (int c = 0; c <= last; c++) begin
            rx_ready     = (c == rx_at);
            match_done   = (c == md_at);
            match_errors = (c == md_at) ? errs : '1;
            match_equal  = (c == md_at) ? eq : ~eq;
            @(negedge clk);
        end
        rx_ready = 1'b0; match_done = 1'b0; match_errors = '0; match_equal = 1'b0;
        check("accum_state", state_dbg, ST_ACCUM);
        check("trial_clear", trial_clear, 1);
    endtask

    task automatic check_done(input int tot, input int eqc, input int toc);
        @(negedge clk);
        check("done", done, 1);
        check("busy_low", busy, 0);
        check("trial_count", trial_count, NUM_TRIALS);
        check("total_errors", total_errors, tot);
        check("equal_count", equal_count, eqc);
        check("timeout_count", timeout_count, toc);
        check("clear_pulses", clr_pulses, NUM_TRIALS);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_state", state_dbg, ST_IDLE);
        check("reset_outputs", {tx_valid, tx_string, tx_eos, trial_clear, busy, done,
                                trial_count, total_errors, equal_count, timeout_count}, 0);

        // Run 1: clean echo, first transfer held off 10 cycles.
        do_start(32'hDEAD_BEEF, 5'd0);
        check("start_latency_no_valid", tx_valid, 0);
        drive_trial(10, 5, 40, 6'd0, 1'b1, 32'hDEAD_BEEF);
        drive_trial(0, 5, 40, 6'd0, 1'b1, 32'hBD5B_7DDE);
        drive_trial(0, 5, 40, 6'd0, 1'b1, 32'h7AB6_FBBC);
        drive_trial(0, 5, 40, 6'd0, 1'b1, 32'hF56D_F779);
        check_done(0, 4, 0);

        // Run 2: zero seed, errors 3,0,7,1; third trial's match lands on expiry.
        do_start(32'h0, 5'd0);
        drive_trial(0, 3, 20, 6'd3, 1'b0, 32'h1);
        drive_trial(0, 3, 20, 6'd0, 1'b1, 32'h3);
        drive_trial(0, 10, TIMEOUT - 1, 6'd7, 1'b0, 32'h6);
        drive_trial(0, 3, 20, 6'd1, 1'b0, 32'hD);
        check_done(11, 1, 0);

        // Run 3: eos=8, receiver silent on trial 2 -> 32-8 errors charged.
        do_start(32'h0, 5'd8);
        check("tx_eos", tx_eos, 8);
        drive_trial(0, 2, 6, 6'd1, 1'b0, 32'h1);
        drive_trial(0, 2, 6, 6'd2, 1'b0, 32'h3);
        drive_trial(0, -1, -1, 6'd0, 1'b0, 32'h6);
        drive_trial(0, 2, 6, 6'd3, 1'b0, 32'hD);
        check_done(30, 0, 1);

        // Run 4: reset while waiting for the checker, then a fresh run.
        do_start(32'hDEAD_BEEF, 5'd3);
        @(negedge clk);
        check("abort_send", tx_valid, 1);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0; rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("abort_wait_match", state_dbg, ST_WAIT_MATCH);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", state_dbg, ST_IDLE);
        check("abort_outputs", {tx_valid, tx_string, tx_eos, trial_clear, busy, done,
                                trial_count, total_errors, equal_count, timeout_count}, 0);
        do_start(32'hDEAD_BEEF, 5'd0);
        drive_trial(0, 1, 4, 6'd0, 1'b1, 32'hDEAD_BEEF);
        drive_trial(0, 1, 4, 6'd0, 1'b1, 32'hBD5B_7DDE);
        drive_trial(0, 1, 4, 6'd0, 1'b1, 32'h7AB6_FBBC);
        drive_trial(0, 1, 4, 6'd0, 1'b1, 32'hF56D_F779);
        check_done(0, 4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/covert_trial_ctrl.md
# covert_trial_ctrl

Trial sequencer for the covert-channel FPGA harness. It runs NUM_TRIALS back-to-back string transmissions. For each trial it generates a test string, hands it to the transmitter, and waits for the receiver to report its decoded string and for the bit-match checker to finish. It then accumulates per-trial error counts into run-level statistics. It sits above the transmitter, receiver and match checker, and is the only block that restarts them between trials.

## Interface
- STR_LEN, 32: string width in bits.
- LOG_STR_LEN, 5: $clog2(STR_LEN).
- NUM_TRIALS, 16: trials per run, ≥1.
- TIMEOUT, 4096: max cycles allowed from tx handshake to match_done.

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a run; honoured only in IDLE or DONE.
- seed  in  STR_LEN  first trial's string; sampled on accepted start.
- eos_cfg  in  LOG_STR_LEN  first compared bit index; sampled on accepted start.
- tx_valid  out  1  string offered to transmitter.
- tx_ready  in  1  transmitter accepts; transfer when tx_valid && tx_ready.
- tx_string  out  STR_LEN  current trial string (also the checker's reference string).
- tx_eos  out  LOG_STR_LEN  latched eos_cfg.
- rx_ready  in  1  receiver output string valid (receiver's outstring_ready).
- match_done  in  1  checker finished the trial.
- match_equal  in  1  checker's whole-string equality.
- match_errors  in  LOG_STR_LEN+1  checker's error count.
- trial_clear  out  1  one-cycle pulse that restarts receiver and checker.
- busy  out  1  run in progress.
- done  out  1  run complete; results stable.
- trial_count  out  $clog2(NUM_TRIALS+1)  trials completed.
- total_errors  out  LOG_STR_LEN+1+$clog2(NUM_TRIALS+1)  accumulated bit errors.
- equal_count  out  $clog2(NUM_TRIALS+1)  trials with match_equal=1.
- timeout_count  out  $clog2(NUM_TRIALS+1)  trials ended by timeout.

## Operation
- **States:** IDLE, LOAD, SEND, WAIT_RX, WAIT_MATCH, ACCUM, DONE.
- **IDLE/DONE + start:**
  - Clear all counters.
  - Latch eos_cfg.
  - String register ← seed, or 1 if seed==0.
  - Go to LOAD.
- **LOAD:**
  - Trial 0 keeps the seeded string.
  - Later trials advance the Fibonacci LFSR one step (taps from package).
  - Go to SEND.
- **SEND:** assert tx_valid; tx_string/tx_eos held stable. On handshake → WAIT_RX and clear the timeout counter.
- **WAIT_RX:** on rx_ready → WAIT_MATCH.
- **WAIT_MATCH:** on match_done, capture match_errors and match_equal → ACCUM.
- **Timeout:**
  - The counter runs in WAIT_RX and WAIT_MATCH.
  - It expires when it reaches TIMEOUT-1 without completion.
  - On expiry, the captured errors become STR_LEN − eos (all compared bits count as wrong), equal=0, timeout_count+1, then → ACCUM.
- **ACCUM:**
  - total_errors += captured errors.
  - equal_count += captured equal.
  - trial_count += 1.
  - trial_clear=1.
  - Next state is DONE if the new trial_count == NUM_TRIALS, else LOAD.
- **DONE:** done=1, busy=0. Results hold until start or rst.
- **Width:** accumulators are sized so they cannot overflow at NUM_TRIALS × STR_LEN. No saturation logic.

## Timing
- **Reset values:**
  - All outputs 0, state IDLE.
  - tx_string = 0, tx_eos = 0.
- **Mid-run reset:** rst mid-run aborts on the next edge. No trial_clear is issued; the system-level reset restarts the peers.
- **Start latency:** start to first tx_valid is 2 cycles (IDLE→LOAD→SEND).
- **Trial overhead:** 3 cycles per trial excluding peer latency (ACCUM, LOAD, SEND minimum).
- **tx_valid rules:**
  - tx_valid is not withdrawn before the handshake.
  - tx_valid falls in the cycle after the handshake.
- **Captures:**
  - match_equal and match_errors are sampled only in the match_done cycle.
  - match_done arriving in WAIT_RX is ignored.
- **Timeout vs match_done:** match_done in the same cycle as timeout expiry means match wins and no timeout is counted.
- **trial_clear:** exactly one pulse per completed trial, issued in the ACCUM cycle.
- **busy:** high from the cycle after an accepted start through ACCUM of the last trial.
- **start while busy:** ignored.

## Structure
- Package covert_pkg holds:
  - STR_LEN/LOG_STR_LEN defaults.
  - LFSR tap constants per STR_LEN.
  - The state enum.
- Sub-module lfsr_step, combinational one-step LFSR:
  - Parameter STR_LEN.
  - Zero state maps to 1.
  - Reusable by the transmitter test pattern logic.

## Test plan
- STR_LEN=32, NUM_TRIALS=4, seed=0xDEADBEEF, eos_cfg=0; model peers echo the string, match_done 40 cycles after tx handshake with errors=0, equal=1 → done=1, trial_count=4, total_errors=0, equal_count=4, 4 trial_clear pulses, trial 1 string = lfsr_step(0xDEADBEEF).
- Checker returns errors 3,0,7,1 → total_errors=11, equal_count=1.
- eos_cfg=8, TIMEOUT=64, rx_ready never asserted on trial 2 → that trial adds 24, timeout_count=1, run still completes.
- tx_ready held low 10 cycles → tx_valid and tx_string stable throughout, single transfer, no extra trial.
- match_done coincident with timeout expiry → timeout_count=0, captured errors used.
- rst asserted in WAIT_MATCH → next cycle: state IDLE, all outputs 0; start afterwards runs a fresh 4-trial run with counters from 0.
